// File: rtl/prefetcher_data_ooo_pkg.sv
// Shared types for the out-of-order prefetcher data queue: error codes and
// the per-slot bookkeeping record.
package prefetcher_pkg;

  localparam int PF_LOG_SLOTS     = 3;
  localparam int PF_LOG_MAX_BEATS = 3;
  localparam int PF_DATA_BITS     = 512;
  localparam int PF_ADDR_BITS     = 64;
  localparam int PF_PROMISE_WIDTH = 3;

  typedef enum logic [2:0] {
    ERR_NONE         = 3'd0,
    ERR_FULL         = 3'd2,
    ERR_RD_OVF       = 3'd4,
    ERR_PROM_SAT     = 3'd5,
    ERR_LEN_MISMATCH = 3'd6
  } err_code_e;

  // wrBeat carries one extra bit so a full 2^LOG_MAX_BEATS burst can be counted.
  typedef struct packed {
    logic                        valid;
    logic [PF_ADDR_BITS-1:0]     addr;
    logic [PF_LOG_MAX_BEATS-1:0] len;
    logic [PF_LOG_MAX_BEATS:0]   wrBeat;
    logic                        complete;
    logic [PF_PROMISE_WIDTH-1:0] promise;
    logic                        consumed;
  } slot_meta_t;

endpackage

// File: rtl/pf_slot_cam.sv
// Address match across the valid burst slots; reports a hit and the lowest
// matching slot index.
module pf_slot_cam #(
  parameter int LOG_SLOTS = 3,
  parameter int ADDR_BITS = 64
) (
  input  logic [(1<<LOG_SLOTS)-1:0] i_valid,
  input  logic [ADDR_BITS-1:0]      i_addr [1<<LOG_SLOTS],
  input  logic [ADDR_BITS-1:0]      i_key,
  output logic                      o_hit,
  output logic [LOG_SLOTS-1:0]      o_idx
);

  localparam int SLOTS = 1 << LOG_SLOTS;

  // Scanning downward leaves the lowest matching index in o_idx.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (i_valid[i] && (i_addr[i] == i_key)) begin
        o_hit = 1'b1;
        o_idx = LOG_SLOTS'(i);
      end
    end
  end

endmodule

// File: rtl/prefetcher_data_ooo.sv
// Prefetcher data queue: a ring of burst slots filled by out-of-order AXI R
// beats (steered by ID = slot index) and drained in order toward the master.
module prefetcher_data_ooo
  import prefetcher_pkg::*;
#(
  parameter int LOG_SLOTS     = PF_LOG_SLOTS,
  parameter int LOG_MAX_BEATS = PF_LOG_MAX_BEATS,
  parameter int DATA_BITS     = PF_DATA_BITS,
  parameter int ADDR_BITS     = PF_ADDR_BITS,
  parameter int PROMISE_WIDTH = PF_PROMISE_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [LOG_SLOTS-1:0]     crs_almostFullSpacer,
  input  logic                     alloc_valid,
  output logic                     alloc_ready,
  input  logic                     alloc_isPref,
  input  logic [ADDR_BITS-1:0]     alloc_addr,
  input  logic [LOG_MAX_BEATS-1:0] alloc_len,
  output logic [LOG_SLOTS-1:0]     alloc_id,
  input  logic                     mreq_valid,
  input  logic [ADDR_BITS-1:0]     mreq_addr,
  output logic                     mreq_hit,
  input  logic                     rd_valid,
  input  logic [LOG_SLOTS-1:0]     rd_id,
  input  logic [DATA_BITS-1:0]     rd_data,
  input  logic                     rd_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_BITS-1:0]     out_data,
  output logic                     out_last,
  output logic [LOG_SLOTS:0]       prefetchReqCnt,
  output logic [LOG_SLOTS:0]       validCnt,
  output logic                     almostFull,
  output logic                     hasOutstanding,
  output logic [2:0]               errorCode
);

  localparam int SLOTS = 1 << LOG_SLOTS;
  localparam int BEATS = 1 << LOG_MAX_BEATS;

  typedef logic [LOG_SLOTS-1:0] idx_t;

  // Handshakes: a channel transfers on a cycle where its valid is high and,
  // for alloc/out, the matching ready is high; all channels are independent.
  slot_meta_t               r_meta      [SLOTS];
  slot_meta_t               w_meta_next [SLOTS];
  logic [DATA_BITS-1:0]     r_data      [SLOTS][BEATS];
  idx_t                     r_head;
  idx_t                     r_tail;
  logic [LOG_MAX_BEATS-1:0] r_rd_beat;
  err_code_e                r_err;
  err_code_e                w_err_next;

  logic [SLOTS-1:0]         w_valid_vec;
  logic [ADDR_BITS-1:0]     w_addr_arr [SLOTS];
  logic [LOG_SLOTS:0]       w_valid_cnt;
  logic [LOG_SLOTS:0]       w_pref_cnt;
  logic                     w_outstanding;
  logic                     w_full;
  logic                     w_hit;
  idx_t                     w_hit_idx;
  idx_t                     w_head_nxt;
  logic                     w_alloc;
  logic                     w_hit_fire;
  logic                     w_hit_sat;
  logic                     w_rd_ok;
  logic                     w_rd_drop;
  logic                     w_rd_at_len;
  logic                     w_rd_mismatch;
  logic                     w_out_valid;
  logic                     w_pop;
  logic                     w_pop_last;
  logic                     w_retire;

  always_comb begin
    w_valid_cnt   = '0;
    w_pref_cnt    = '0;
    w_outstanding = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      w_valid_vec[i] = r_meta[i].valid;
      w_addr_arr[i]  = r_meta[i].addr;
      w_valid_cnt    = w_valid_cnt + (LOG_SLOTS+1)'(r_meta[i].valid);
      w_pref_cnt     = w_pref_cnt + (LOG_SLOTS+1)'(r_meta[i].valid &&
                       (r_meta[i].promise == '0) && !r_meta[i].consumed);
      w_outstanding  = w_outstanding | (r_meta[i].valid && !r_meta[i].complete);
    end
  end

  pf_slot_cam #(
    .LOG_SLOTS (LOG_SLOTS),
    .ADDR_BITS (ADDR_BITS)
  ) u_cam (
    .i_valid (w_valid_vec),
    .i_addr  (w_addr_arr),
    .i_key   (mreq_addr),
    .o_hit   (w_hit),
    .o_idx   (w_hit_idx)
  );

  assign w_full     = (w_valid_cnt == (LOG_SLOTS+1)'(SLOTS));
  assign w_head_nxt = r_head + idx_t'(1);
  assign w_alloc    = alloc_valid && !w_full;
  assign w_hit_fire = mreq_valid && w_hit;
  assign w_hit_sat  = w_hit_fire && (&r_meta[w_hit_idx].promise);

  assign w_rd_ok       = rd_valid && r_meta[rd_id].valid && !r_meta[rd_id].complete;
  assign w_rd_drop     = rd_valid && !w_rd_ok;
  assign w_rd_at_len   = (r_meta[rd_id].wrBeat == {1'b0, r_meta[rd_id].len});
  assign w_rd_mismatch = w_rd_ok && (rd_last != w_rd_at_len);

  assign w_out_valid = r_meta[r_head].valid && (r_meta[r_head].promise != '0) &&
                       (r_meta[r_head].wrBeat > {1'b0, r_rd_beat});
  assign w_pop       = w_out_valid && out_ready;
  assign w_pop_last  = w_pop && (r_rd_beat == r_meta[r_head].len);

  // A hit landing on the head this cycle keeps it alive for the promised read.
  assign w_retire = r_meta[r_head].valid && (r_meta[r_head].promise == '0) &&
                    r_meta[r_head].complete &&
                    (r_meta[r_head].consumed ||
                     (r_meta[w_head_nxt].valid && (r_meta[w_head_nxt].promise != '0))) &&
                    !(w_hit_fire && (w_hit_idx == r_head));

  always_comb begin
    if (w_rd_mismatch)                w_err_next = ERR_LEN_MISMATCH;
    else if (w_hit_sat)               w_err_next = ERR_PROM_SAT;
    else if (w_rd_drop)               w_err_next = ERR_RD_OVF;
    else if (alloc_valid && w_full)   w_err_next = ERR_FULL;
    else                              w_err_next = ERR_NONE;
  end

  // Next-state of the slot table; hit and final pop on one slot net to zero.
  always_comb begin
    w_meta_next = r_meta;
    if (w_hit_fire) begin
      w_meta_next[w_hit_idx].consumed = 1'b1;
      if (!w_hit_sat)
        w_meta_next[w_hit_idx].promise = r_meta[w_hit_idx].promise + PROMISE_WIDTH'(1);
    end
    // Serving the full burst counts as consumption so a master-miss slot retires.
    if (w_pop_last) begin
      w_meta_next[r_head].promise  = w_meta_next[r_head].promise - PROMISE_WIDTH'(1);
      w_meta_next[r_head].consumed = 1'b1;
    end
    if (w_rd_ok) begin
      w_meta_next[rd_id].wrBeat = r_meta[rd_id].wrBeat + (LOG_MAX_BEATS+1)'(1);
      if (rd_last || w_rd_at_len)
        w_meta_next[rd_id].complete = 1'b1;
    end
    if (w_retire)
      w_meta_next[r_head].valid = 1'b0;
    if (w_alloc) begin
      w_meta_next[r_tail].valid    = 1'b1;
      w_meta_next[r_tail].addr     = alloc_addr;
      w_meta_next[r_tail].len      = alloc_len;
      w_meta_next[r_tail].wrBeat   = '0;
      w_meta_next[r_tail].complete = 1'b0;
      w_meta_next[r_tail].promise  = {{(PROMISE_WIDTH-1){1'b0}}, !alloc_isPref};
      w_meta_next[r_tail].consumed = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SLOTS; i++) r_meta[i] <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_rd_beat <= '0;
      r_err     <= ERR_NONE;
    end else if (flush) begin
      for (int i = 0; i < SLOTS; i++) r_meta[i] <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_rd_beat <= '0;
      r_err     <= ERR_NONE;
    end else begin
      r_meta <= w_meta_next;
      r_err  <= w_err_next;
      if (w_alloc)  r_tail <= r_tail + idx_t'(1);
      if (w_retire) r_head <= w_head_nxt;
      if (w_pop)    r_rd_beat <= w_pop_last ? '0 : r_rd_beat + LOG_MAX_BEATS'(1);
    end
  end

  // Beat storage carries no reset; slot validity gates every read of it.
  always_ff @(posedge clk) begin
    if (w_rd_ok && !flush)
      r_data[rd_id][r_meta[rd_id].wrBeat[LOG_MAX_BEATS-1:0]] <= rd_data;
  end

  assign alloc_ready    = !w_full;
  assign alloc_id       = r_tail;
  assign mreq_hit       = w_hit;
  assign out_valid      = w_out_valid;
  assign out_data       = r_data[r_head][r_rd_beat];
  assign out_last       = w_out_valid && (r_rd_beat == r_meta[r_head].len);
  assign prefetchReqCnt = w_pref_cnt;
  assign validCnt       = w_valid_cnt;
  assign almostFull     = (({1'b0, w_valid_cnt} + (LOG_SLOTS+2)'(crs_almostFullSpacer))
                           >= (LOG_SLOTS+2)'(SLOTS));
  assign hasOutstanding = w_outstanding;
  assign errorCode      = r_err;

endmodule

// File: tb/tb_prefetcher_data_ooo.sv
// Directed bench for prefetcher_data_ooo: in-order and out-of-order bursts,
// prefetch hits, stale skip, full/error paths and asynchronous reset.
module tb_prefetcher_data_ooo;

  localparam int DW = 512;
  localparam int AW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic [2:0]    crs_almostFullSpacer;
  logic          alloc_valid;
  logic          alloc_ready;
  logic          alloc_isPref;
  logic [AW-1:0] alloc_addr;
  logic [2:0]    alloc_len;
  logic [2:0]    alloc_id;
  logic          mreq_valid;
  logic [AW-1:0] mreq_addr;
  logic          mreq_hit;
  logic          rd_valid;
  logic [2:0]    rd_id;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [3:0]    prefetchReqCnt;
  logic [3:0]    validCnt;
  logic          almostFull;
  logic          hasOutstanding;
  logic [2:0]    errorCode;

  int n_cmp = 0;
  int n_err = 0;

  // Each entry: {last, data}
  logic [DW:0] exp_q[$];

  prefetcher_data_ooo dut (
    .clk                  (clk),
    .reset                (reset),
    .flush                (flush),
    .crs_almostFullSpacer (crs_almostFullSpacer),
    .alloc_valid          (alloc_valid),
    .alloc_ready          (alloc_ready),
    .alloc_isPref         (alloc_isPref),
    .alloc_addr           (alloc_addr),
    .alloc_len            (alloc_len),
    .alloc_id             (alloc_id),
    .mreq_valid           (mreq_valid),
    .mreq_addr            (mreq_addr),
    .mreq_hit             (mreq_hit),
    .rd_valid             (rd_valid),
    .rd_id                (rd_id),
    .rd_data              (rd_data),
    .rd_last              (rd_last),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_data             (out_data),
    .out_last             (out_last),
    .prefetchReqCnt       (prefetchReqCnt),
    .validCnt             (validCnt),
    .almostFull           (almostFull),
    .hasOutstanding       (hasOutstanding),
    .errorCode            (errorCode)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input int tag, input int k);
    return {16{32'(tag * 16 + k)}};
  endfunction

  // Drivers are entered just after a rising edge and return just after one.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc_do(input logic pref, input logic [AW-1:0] addr,
                          input logic [2:0] len, input logic [2:0] exp_id);
    alloc_valid  = 1'b1;
    alloc_isPref = pref;
    alloc_addr   = addr;
    alloc_len    = len;
    #1;
    check_eq("alloc_ready", DW'(alloc_ready), DW'(1));
    check_eq("alloc_id", DW'(alloc_id), DW'(exp_id));
    step();
    alloc_valid = 1'b0;
  endtask

  task automatic beat(input logic [2:0] id, input logic [DW-1:0] d, input logic last);
    rd_valid = 1'b1;
    rd_id    = id;
    rd_data  = d;
    rd_last  = last;
    step();
    rd_valid = 1'b0;
    rd_last  = 1'b0;
  endtask

  // Feed a whole burst and optionally queue it as expected output.
  task automatic burst(input logic [2:0] id, input int tag, input int nbeats, input bit expect_out);
    for (int k = 0; k < nbeats; k++) begin
      beat(id, mk_data(tag, k), (k == nbeats - 1));
      if (expect_out) exp_q.push_back({(k == nbeats - 1), mk_data(tag, k)});
    end
  endtask

  task automatic drain(input int n, input int budget);
    logic [DW:0] e;
    int got;
    got = 0;
    out_ready = 1'b1;
    for (int c = 0; c < budget && got < n; c++) begin
      #1;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("exp_q_empty", DW'(exp_q.size()), DW'(1));
        end else begin
          e = exp_q.pop_front();
          check_eq("out_data", out_data, e[DW-1:0]);
          check_eq("out_last", DW'(out_last), DW'(e[DW]));
        end
        got++;
      end
      step();
    end
    out_ready = 1'b0;
    check_eq("drain_cnt", DW'(got), DW'(n));
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    crs_almostFullSpacer = 3'd2;
    alloc_valid = 1'b0; alloc_isPref = 1'b0; alloc_addr = '0; alloc_len = '0;
    mreq_valid = 1'b0; mreq_addr = '0;
    rd_valid = 1'b0; rd_id = '0; rd_data = '0; rd_last = 1'b0;
    out_ready = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();

    // reset state
    check_eq("rst_alloc_ready", DW'(alloc_ready), DW'(1));
    check_eq("rst_out_valid", DW'(out_valid), DW'(0));
    check_eq("rst_validCnt", DW'(validCnt), DW'(0));
    check_eq("rst_prefCnt", DW'(prefetchReqCnt), DW'(0));
    check_eq("rst_almostFull", DW'(almostFull), DW'(0));
    check_eq("rst_outstanding", DW'(hasOutstanding), DW'(0));
    check_eq("rst_errorCode", DW'(errorCode), DW'(0));

    // 4-beat master-miss burst, in order, then retirement
    alloc_do(1'b0, 64'h1000, 3'd3, 3'd0);
    #1;
    check_eq("t1_validCnt", DW'(validCnt), DW'(1));
    check_eq("t1_outstanding", DW'(hasOutstanding), DW'(1));
    burst(3'd0, 1, 4, 1'b1);
    #1;
    check_eq("t1_complete", DW'(hasOutstanding), DW'(0));
    drain(4, 20);
    step();
    #1;
    check_eq("t1_retired", DW'(validCnt), DW'(0));

    // out-of-order return: B data first, A must still come out first
    alloc_do(1'b0, 64'h3000, 3'd1, 3'd1);
    alloc_do(1'b0, 64'h3040, 3'd1, 3'd2);
    burst(3'd2, 3, 2, 1'b0);
    #1;
    check_eq("t2_blocked", DW'(out_valid), DW'(0));
    burst(3'd1, 2, 2, 1'b1);
    for (int k = 0; k < 2; k++) exp_q.push_back({(k == 1), mk_data(3, k)});
    drain(4, 20);
    step();
    #1;
    check_eq("t2_retired", DW'(validCnt), DW'(0));

    // prefetch, then master hit turns it into a served burst
    alloc_do(1'b1, 64'h2000, 3'd0, 3'd3);
    #1;
    check_eq("t3_prefCnt1", DW'(prefetchReqCnt), DW'(1));
    burst(3'd3, 4, 1, 1'b1);
    #1;
    check_eq("t3_no_promise", DW'(out_valid), DW'(0));
    mreq_valid = 1'b1;
    mreq_addr  = 64'h2100;
    #1;
    check_eq("t3_miss", DW'(mreq_hit), DW'(0));
    mreq_addr  = 64'h2000;
    #1;
    check_eq("t3_hit", DW'(mreq_hit), DW'(1));
    step();
    mreq_valid = 1'b0;
    #1;
    check_eq("t3_prefCnt0", DW'(prefetchReqCnt), DW'(0));
    drain(1, 10);
    step();
    #1;
    check_eq("t3_retired", DW'(validCnt), DW'(0));

    // stale prefetch skipped in favour of the following master burst
    alloc_do(1'b1, 64'h4000, 3'd0, 3'd4);
    alloc_do(1'b0, 64'h5000, 3'd0, 3'd5);
    burst(3'd4, 5, 1, 1'b0);
    burst(3'd5, 6, 1, 1'b1);
    drain(1, 10);
    step();
    #1;
    check_eq("t4_empty", DW'(validCnt), DW'(0));

    // fill the ring, almostFull threshold, full error pulse
    for (int i = 0; i < 8; i++) begin
      alloc_do(1'b1, 64'h6000 + 64'(i * 64), 3'd0, 3'((6 + i) % 8));
      #1;
      check_eq("t5_validCnt", DW'(validCnt), DW'(i + 1));
      check_eq("t5_almostFull", DW'(almostFull), DW'((i + 1 + 2) >= 8));
    end
    check_eq("t5_prefCnt", DW'(prefetchReqCnt), DW'(8));
    check_eq("t5_not_ready", DW'(alloc_ready), DW'(0));
    alloc_valid = 1'b1;
    step();
    alloc_valid = 1'b0;
    #1;
    check_eq("t5_err_full", DW'(errorCode), DW'(2));
    check_eq("t5_cnt_kept", DW'(validCnt), DW'(8));
    step();
    #1;
    check_eq("t5_err_pulse", DW'(errorCode), DW'(0));

    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    check_eq("flush_validCnt", DW'(validCnt), DW'(0));
    check_eq("flush_ready", DW'(alloc_ready), DW'(1));
    beat(3'd3, mk_data(7, 0), 1'b1);
    #1;
    check_eq("t5_err_rd_ovf", DW'(errorCode), DW'(4));

    // promise saturation and length mismatch
    alloc_do(1'b0, 64'h7000, 3'd0, 3'd0);
    mreq_valid = 1'b1;
    mreq_addr  = 64'h7000;
    repeat (6) step();
    #1;
    check_eq("t6_no_sat_yet", DW'(errorCode), DW'(0));
    step();
    mreq_valid = 1'b0;
    #1;
    check_eq("t6_err_sat", DW'(errorCode), DW'(5));
    beat(3'd0, mk_data(8, 0), 1'b0);
    #1;
    check_eq("t6_err_len", DW'(errorCode), DW'(6));
    check_eq("t6_completed", DW'(hasOutstanding), DW'(0));
    check_eq("t6_out_valid", DW'(out_valid), DW'(1));
    check_eq("t6_out_data", out_data, mk_data(8, 0));
    flush = 1'b1;
    step();
    flush = 1'b0;

    // asynchronous reset in the middle of a burst
    alloc_do(1'b0, 64'h8000, 3'd3, 3'd0);
    burst(3'd0, 9, 4, 1'b0);
    exp_q.push_back({1'b0, mk_data(9, 0)});
    exp_q.push_back({1'b0, mk_data(9, 1)});
    drain(2, 10);
    #1;
    check_eq("t7_mid_burst", DW'(out_valid), DW'(1));
    #1;
    reset = 1'b1;
    #1;
    check_eq("t7_out_valid", DW'(out_valid), DW'(0));
    check_eq("t7_validCnt", DW'(validCnt), DW'(0));
    check_eq("t7_ready", DW'(alloc_ready), DW'(1));
    check_eq("t7_outstanding", DW'(hasOutstanding), DW'(0));
    check_eq("t7_errorCode", DW'(errorCode), DW'(0));
    step();
    reset = 1'b0;
    step();
    alloc_do(1'b0, 64'h9000, 3'd0, 3'd0);
    #1;
    check_eq("t7_validCnt1", DW'(validCnt), DW'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
